alu_core: RTL



---
 rtl/alu_pkg.sv | 91 +++++++++
 rtl/alu_if.sv | 37 +++
 rtl/alu_exec.sv | 113 +++++++++++
 rtl/alu_core.sv | 133 +++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// alu_pkg : opcodes, FSM states, default sizes and result width for alu_core
// Rev 1.0
// ============================================================================
package alu_pkg;

  localparam int OP_WIDTH_DEF  = 8;
  localparam int CMD_WIDTH_DEF = 4;
  localparam int TIMEOUT_DEF   = 16;

  function automatic int res_width(input int op_w);
`ifdef MUL_OP_EN
    return 2 * op_w;
`else
    return op_w + 1;
`endif
  endfunction

  localparam int RES_WIDTH = res_width(OP_WIDTH_DEF);

  typedef enum logic [3:0] {
    A_ADD     = 4'd0,
    A_SUB     = 4'd1,
    A_ADD_CIN = 4'd2,
    A_SUB_CIN = 4'd3,
    A_INC_A   = 4'd4,
    A_DEC_A   = 4'd5,
    A_INC_B   = 4'd6,
    A_DEC_B   = 4'd7,
    A_CMP     = 4'd8,
    A_INC_MUL = 4'd9,
    A_SHL_MUL = 4'd10
  } arith_cmd_e;

  typedef enum logic [3:0] {
    L_AND     = 4'd0,
    L_NAND    = 4'd1,
    L_OR      = 4'd2,
    L_NOR     = 4'd3,
    L_XOR     = 4'd4,
    L_XNOR    = 4'd5,
    L_NOT_A   = 4'd6,
    L_NOT_B   = 4'd7,
    L_SHR1_A  = 4'd8,
    L_SHL1_A  = 4'd9,
    L_SHR1_B  = 4'd10,
    L_SHL1_B  = 4'd11,
    L_ROL_A_B = 4'd12,
    L_ROR_A_B = 4'd13
  } logic_cmd_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT_A = 2'd1,
    S_WAIT_B = 2'd2
`ifdef MUL_OP_EN
    ,
    S_MUL    = 2'd3
`endif
  } state_e;

  // Operand-valid mask an opcode needs; 2'b00 marks an undefined opcode
  // that completes (with err) as soon as any operand shows up.
  function automatic logic [1:0] need_ops(input logic mode, input logic [3:0] cmd);
    logic [1:0] n;
    n = 2'b00;
    if (mode) begin
      case (cmd)
        A_ADD, A_SUB, A_ADD_CIN, A_SUB_CIN, A_CMP: n = 2'b11;
        A_INC_A, A_DEC_A:                          n = 2'b01;
        A_INC_B, A_DEC_B:                          n = 2'b10;
`ifdef MUL_OP_EN
        A_INC_MUL, A_SHL_MUL:                      n = 2'b11;
`endif
        default:                                   n = 2'b00;
      endcase
    end else begin
      case (cmd)
        L_AND, L_NAND, L_OR, L_NOR, L_XOR, L_XNOR,
        L_ROL_A_B, L_ROR_A_B:                      n = 2'b11;
        L_NOT_A, L_SHR1_A, L_SHL1_A:               n = 2'b01;
        L_NOT_B, L_SHR1_B, L_SHL1_B:               n = 2'b10;
        default:                                   n = 2'b00;
      endcase
    end
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_if.sv
`default_nettype none
// ============================================================================
// alu_if : stimulus/response bus between the driver and alu_core
// Rev 1.0
// ============================================================================
interface alu_if import alu_pkg::*; #(
  parameter int OP_WIDTH  = OP_WIDTH_DEF,
  parameter int CMD_WIDTH = CMD_WIDTH_DEF
);
  localparam int RES_W = res_width(OP_WIDTH);

  logic                 ce;
  logic                 mode;
  logic [CMD_WIDTH-1:0] cmd;
  logic                 cin;
  logic [1:0]           inp_valid;
  logic [OP_WIDTH-1:0]  opa;
  logic [OP_WIDTH-1:0]  opb;
  logic [RES_W-1:0]     res;
  logic                 cout;
  logic                 oflow;
  logic                 g;
  logic                 l;
  logic                 e;
  logic                 err;

  modport master (
    output ce, mode, cmd, cin, inp_valid, opa, opb,
    input  res, cout, oflow, g, l, e, err
  );

  modport slave (
    input  ce, mode, cmd, cin, inp_valid, opa, opb,
    output res, cout, oflow, g, l, e, err
  );
endinterface
`default_nettype wire

// File: rtl/alu_exec.sv
`default_nettype none
// ============================================================================
// alu_exec : combinational ALU datapath producing res and flags
// Rev 1.0
// ============================================================================
module alu_exec import alu_pkg::*; #(
  parameter int OP_WIDTH  = OP_WIDTH_DEF,
  parameter int CMD_WIDTH = CMD_WIDTH_DEF,
  parameter int RES_W     = res_width(OP_WIDTH)
) (
  input  logic [OP_WIDTH-1:0]  a_i,
  input  logic [OP_WIDTH-1:0]  b_i,
  input  logic [CMD_WIDTH-1:0] cmd_i,
  input  logic                 mode_i,
  input  logic                 cin_i,
  output logic [RES_W-1:0]     res_o,
  output logic                 cout_o,
  output logic                 oflow_o,
  output logic                 g_o,
  output logic                 l_o,
  output logic                 e_o,
`ifdef MUL_OP_EN
  output logic                 is_mul_o,
`endif
  output logic                 err_o
);
  localparam int NW   = OP_WIDTH + 1;
  localparam int SH_W = $clog2(OP_WIDTH);

  logic [NW-1:0]         add_w, addc_w, sub_w, subc_w, nres;
  logic [2*OP_WIDTH-1:0] rol_full, ror_full;
  logic [SH_W-1:0]       rot;
  logic                  rot_err;

  assign add_w    = {1'b0, a_i} + {1'b0, b_i};
  assign addc_w   = add_w + {{OP_WIDTH{1'b0}}, cin_i};
  assign sub_w    = {1'b0, a_i} - {1'b0, b_i};
  assign subc_w   = sub_w - {{OP_WIDTH{1'b0}}, cin_i};
  assign rot      = b_i[SH_W-1:0];
  assign rol_full = {a_i, a_i} << rot;
  assign ror_full = {a_i, a_i} >> rot;
  assign rot_err  = |b_i[OP_WIDTH-1:SH_W];

`ifdef MUL_OP_EN
  localparam int PW = 2 * OP_WIDTH;
  logic [PW-1:0] a_ext, b_ext, inc_mul, shl_mul;
  assign a_ext   = {{OP_WIDTH{1'b0}}, a_i};
  assign b_ext   = {{OP_WIDTH{1'b0}}, b_i};
  assign inc_mul = (a_ext + PW'(1)) * (b_ext + PW'(1));
  assign shl_mul = (a_ext << 1) * b_ext;
`endif

  always_comb begin
    nres    = '0;
    res_o   = '0;
    cout_o  = 1'b0;
    oflow_o = 1'b0;
    g_o     = 1'b0;
    l_o     = 1'b0;
    e_o     = 1'b0;
    err_o   = 1'b0;
`ifdef MUL_OP_EN
    is_mul_o = 1'b0;
`endif
    if (mode_i) begin
      case (cmd_i)
        A_ADD:     begin nres = add_w;  cout_o  = add_w[OP_WIDTH];  end
        A_SUB:     begin nres = sub_w;  oflow_o = sub_w[OP_WIDTH];  end
        A_ADD_CIN: begin nres = addc_w; cout_o  = addc_w[OP_WIDTH]; end
        A_SUB_CIN: begin nres = subc_w; oflow_o = subc_w[OP_WIDTH]; end
        A_INC_A:   nres = {1'b0, a_i} + NW'(1);
        A_DEC_A:   nres = {1'b0, a_i} - NW'(1);
        A_INC_B:   nres = {1'b0, b_i} + NW'(1);
        A_DEC_B:   nres = {1'b0, b_i} - NW'(1);
        A_CMP: begin
          g_o = (a_i > b_i);
          l_o = (a_i < b_i);
          e_o = (a_i == b_i);
        end
`ifdef MUL_OP_EN
        A_INC_MUL: is_mul_o = 1'b1;
        A_SHL_MUL: is_mul_o = 1'b1;
`endif
        default:   err_o = 1'b1;
      endcase
    end else begin
      case (cmd_i)
        L_AND:     nres = {1'b0, a_i & b_i};
        L_NAND:    nres = {1'b0, ~(a_i & b_i)};
        L_OR:      nres = {1'b0, a_i | b_i};
        L_NOR:     nres = {1'b0, ~(a_i | b_i)};
        L_XOR:     nres = {1'b0, a_i ^ b_i};
        L_XNOR:    nres = {1'b0, ~(a_i ^ b_i)};
        L_NOT_A:   nres = {1'b0, ~a_i};
        L_NOT_B:   nres = {1'b0, ~b_i};
        L_SHR1_A:  nres = {1'b0, a_i >> 1};
        L_SHL1_A:  nres = {1'b0, a_i << 1};
        L_SHR1_B:  nres = {1'b0, b_i >> 1};
        L_SHL1_B:  nres = {1'b0, b_i << 1};
        L_ROL_A_B: begin nres = {1'b0, rol_full[2*OP_WIDTH-1:OP_WIDTH]}; err_o = rot_err; end
        L_ROR_A_B: begin nres = {1'b0, ror_full[OP_WIDTH-1:0]};          err_o = rot_err; end
        default:   err_o = 1'b1;
      endcase
    end
    res_o = RES_W'(nres);
`ifdef MUL_OP_EN
    if (mode_i && cmd_i == A_INC_MUL) res_o = inc_mul;
    if (mode_i && cmd_i == A_SHL_MUL) res_o = shl_mul;
`endif
  end

endmodule
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
// alu_core : operand-collecting ALU with timeout; MUL_OP_EN adds 2-cycle mul
// Rev 1.0
// ============================================================================
module alu_core import alu_pkg::*; #(
  parameter int OP_WIDTH  = OP_WIDTH_DEF,
  parameter int CMD_WIDTH = CMD_WIDTH_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input logic  clk,
  input logic  rst,
  alu_if.slave bus
);
  localparam int RES_W = res_width(OP_WIDTH);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [OP_WIDTH-1:0]  a_q, a_d, b_q, b_d, ex_a, ex_b;
  logic [CMD_WIDTH-1:0] cmd_q, cmd_d, ex_cmd;
  logic                 mode_q, mode_d, ex_mode, cin_q, cin_d, ex_cin;
  logic [RES_W-1:0]     res_q, res_d, ex_res;
  logic                 cout_q, cout_d, oflow_q, oflow_d, g_q, g_d, l_q, l_d, e_q, e_d;
  logic                 err_q, err_d;
  logic                 ex_cout, ex_oflow, ex_g, ex_l, ex_e, ex_err;
  logic [1:0]           need, missing;
  logic                 fire, commit;
`ifdef MUL_OP_EN
  logic                 ex_is_mul;
`endif

  alu_exec #(.OP_WIDTH(OP_WIDTH), .CMD_WIDTH(CMD_WIDTH), .RES_W(RES_W)) u_exec (
    .a_i(ex_a), .b_i(ex_b), .cmd_i(ex_cmd), .mode_i(ex_mode), .cin_i(ex_cin),
    .res_o(ex_res), .cout_o(ex_cout), .oflow_o(ex_oflow),
    .g_o(ex_g), .l_o(ex_l), .e_o(ex_e),
`ifdef MUL_OP_EN
    .is_mul_o(ex_is_mul),
`endif
    .err_o(ex_err)
  );

  assign need    = need_ops(bus.mode, bus.cmd);
  assign missing = need & ~bus.inp_valid;

  always_comb begin
    state_d = state_q;  cnt_d   = cnt_q;
    a_d     = a_q;      b_d     = b_q;
    cmd_d   = cmd_q;    mode_d  = mode_q;  cin_d = cin_q;
    res_d   = res_q;    cout_d  = cout_q;  oflow_d = oflow_q;
    g_d     = g_q;      l_d     = l_q;     e_d = e_q;  err_d = err_q;
    ex_a    = a_q;      ex_b    = b_q;
    ex_cmd  = cmd_q;    ex_mode = mode_q;  ex_cin = cin_q;
    fire    = 1'b0;
    commit  = 1'b0;
    if (bus.ce) begin
      err_d = 1'b0;
      case (state_q)
        S_IDLE: begin
          ex_a = bus.opa;  ex_b = bus.opb;
          ex_cmd = bus.cmd;  ex_mode = bus.mode;  ex_cin = bus.cin;
          if (bus.inp_valid != 2'b00) begin
            a_d = bus.opa;  b_d = bus.opb;
            cmd_d = bus.cmd;  mode_d = bus.mode;  cin_d = bus.cin;
            if (missing == 2'b00) begin
              fire = 1'b1;
            end else begin
              cnt_d   = '0;
              state_d = missing[0] ? S_WAIT_A : S_WAIT_B;
            end
          end
        end
        S_WAIT_A, S_WAIT_B: begin
          // Either operand may be refreshed; only the missing one completes.
          if (bus.inp_valid[0]) begin ex_a = bus.opa; a_d = bus.opa; end
          if (bus.inp_valid[1]) begin ex_b = bus.opb; b_d = bus.opb; end
          if ((state_q == S_WAIT_A) ? bus.inp_valid[0] : bus.inp_valid[1]) begin
            fire = 1'b1;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
`ifdef MUL_OP_EN
        S_MUL:   commit = 1'b1;
`endif
        default: state_d = S_IDLE;
      endcase
      if (fire) begin
`ifdef MUL_OP_EN
        if (ex_is_mul) state_d = S_MUL;
        else           commit  = 1'b1;
`else
        commit = 1'b1;
`endif
      end
      if (commit) begin
        res_d   = ex_res;   cout_d = ex_cout;  oflow_d = ex_oflow;
        g_d     = ex_g;     l_d    = ex_l;     e_d     = ex_e;
        err_d   = ex_err;
        state_d = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;  cnt_q  <= '0;
      a_q     <= '0;      b_q    <= '0;
      cmd_q   <= '0;      mode_q <= 1'b0;  cin_q   <= 1'b0;
      res_q   <= '0;      cout_q <= 1'b0;  oflow_q <= 1'b0;
      g_q     <= 1'b0;    l_q    <= 1'b0;  e_q     <= 1'b0;  err_q <= 1'b0;
    end else begin
      state_q <= state_d;  cnt_q  <= cnt_d;
      a_q     <= a_d;      b_q    <= b_d;
      cmd_q   <= cmd_d;    mode_q <= mode_d;  cin_q   <= cin_d;
      res_q   <= res_d;    cout_q <= cout_d;  oflow_q <= oflow_d;
      g_q     <= g_d;      l_q    <= l_d;     e_q     <= e_d;  err_q <= err_d;
    end
  end

  assign bus.res   = res_q;
  assign bus.cout  = cout_q;
  assign bus.oflow = oflow_q;
  assign bus.g     = g_q;
  assign bus.l     = l_q;
  assign bus.e     = e_q;
  assign bus.err   = err_q;

endmodule
`default_nettype wire
